// File: rtl/multi_timer_dev.sv
// multi_timer_dev: NUM_CH memory-mapped countdown timers with CTRL/PRESET/COUNT/STATUS
// registers per channel. addr[7:4] selects the channel and addr[3:2] the register.
// Reads are combinational. Each channel raises a maskable pending interrupt when its
// count expires, and all channel interrupts are OR-ed into one irq line.
module multi_timer_dev #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        addr,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq_ch,
    output logic              irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        FIRE = 2'd3
    } state_t;

    localparam logic [1:0]       REG_CTRL   = 2'd0;
    localparam logic [1:0]       REG_PRESET = 2'd1;
    localparam logic [1:0]       REG_COUNT  = 2'd2;
    localparam logic [1:0]       REG_STATUS = 2'd3;
    localparam logic [WIDTH-1:0] CNT_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t                       state_r    [NUM_CH];
    state_t                       state_nx_s [NUM_CH];
    logic [NUM_CH-1:0]            en_r, mode_r, im_r, pend_r;
    logic [NUM_CH-1:0]            en_nx_s, mode_nx_s, im_nx_s, pend_nx_s;
    logic [NUM_CH-1:0][WIDTH-1:0] preset_r, count_r;
    logic [NUM_CH-1:0][WIDTH-1:0] preset_nx_s, count_nx_s;
    logic [NUM_CH-1:0]            fire_s, fsm_clr_en_s, sel_s;
    logic [31:0]                  be_mask_s;
    logic [31:0]                  view_s;
    logic                         addr_unused_s;

    // Byte lanes with their enable set take the new value; the rest keep the old one.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
        byte_merge = (new_v & mask) | (old_v & ~mask);
    endfunction

    // The two low address bits do not select anything.
    assign addr_unused_s = ^addr[1:0];

    // Channel select from the address, plus the byte-lane mask for writes.
    // Channel numbers at or above NUM_CH select nothing.
    always_comb begin
        sel_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr[7:4] == 4'(i)) begin
                sel_s[i] = 1'b1;
            end else begin
                sel_s[i] = 1'b0;
            end
        end
        be_mask_s = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    end

    // Per-channel FSM: next state, counter update and FIRE side effects.
    // Clearing EN aborts any active state, and COUNT keeps its value.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_nx_s[i]   = state_r[i];
            count_nx_s[i]   = count_r[i];
            fire_s[i]       = 1'b0;
            fsm_clr_en_s[i] = 1'b0;
            if ((state_r[i] != IDLE) && !en_r[i]) begin
                state_nx_s[i] = IDLE;
            end else begin
                case (state_r[i])
                    IDLE: begin
                        if (en_r[i]) begin
                            state_nx_s[i] = LOAD;
                        end else begin
                            state_nx_s[i] = IDLE;
                        end
                    end
                    LOAD: begin
                        count_nx_s[i] = preset_r[i];
                        state_nx_s[i] = CNT;
                    end
                    CNT: begin
                        if (count_r[i] > CNT_ONE) begin
                            count_nx_s[i] = count_r[i] - CNT_ONE;
                        end else begin
                            count_nx_s[i] = {WIDTH{1'b0}};
                            state_nx_s[i] = FIRE;
                        end
                    end
                    FIRE: begin
                        fire_s[i] = 1'b1;
                        if (mode_r[i]) begin
                            state_nx_s[i] = LOAD;
                        end else begin
                            fsm_clr_en_s[i] = 1'b1;
                            state_nx_s[i]   = IDLE;
                        end
                    end
                    default: state_nx_s[i] = IDLE;
                endcase
            end
        end
    end

    // Bus write effects, merged with the updates made by the FSM.
    // A FIRE set of PEND beats a W1C. A one-shot FIRE clearing EN beats a CTRL write.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            en_nx_s[i]     = en_r[i];
            mode_nx_s[i]   = mode_r[i];
            im_nx_s[i]     = im_r[i];
            preset_nx_s[i] = preset_r[i];
            pend_nx_s[i]   = pend_r[i] | fire_s[i];
            if (we && sel_s[i]) begin
                case (addr[3:2])
                    REG_CTRL: begin
                        if (be[0]) begin
                            en_nx_s[i]   = wdata[0];
                            mode_nx_s[i] = wdata[1];
                            im_nx_s[i]   = wdata[2];
                        end else begin
                            en_nx_s[i]   = en_r[i];
                            mode_nx_s[i] = mode_r[i];
                            im_nx_s[i]   = im_r[i];
                        end
                    end
                    REG_PRESET: begin
                        preset_nx_s[i] = WIDTH'(byte_merge(32'(preset_r[i]), wdata, be_mask_s));
                    end
                    REG_STATUS: begin
                        if (be[0] && wdata[0]) begin
                            pend_nx_s[i] = fire_s[i];
                        end else begin
                            pend_nx_s[i] = pend_r[i] | fire_s[i];
                        end
                    end
                    default: preset_nx_s[i] = preset_r[i];
                endcase
            end else begin
                en_nx_s[i] = en_r[i];
            end
            en_nx_s[i] = en_nx_s[i] & ~fsm_clr_en_s[i];
        end
    end

    // Channel state registers, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= IDLE;
            end
            en_r     <= {NUM_CH{1'b0}};
            mode_r   <= {NUM_CH{1'b0}};
            im_r     <= {NUM_CH{1'b0}};
            pend_r   <= {NUM_CH{1'b0}};
            preset_r <= {(NUM_CH*WIDTH){1'b0}};
            count_r  <= {(NUM_CH*WIDTH){1'b0}};
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_r[i] <= state_nx_s[i];
            end
            en_r     <= en_nx_s;
            mode_r   <= mode_nx_s;
            im_r     <= im_nx_s;
            pend_r   <= pend_nx_s;
            preset_r <= preset_nx_s;
            count_r  <= count_nx_s;
        end
    end

    // Combinational read of the addressed register. Unmapped channels read zero,
    // and bits at or above WIDTH read zero.
    always_comb begin
        rdata  = 32'd0;
        view_s = 32'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (addr[3:2])
                REG_CTRL:   view_s = {29'd0, im_r[i], mode_r[i], en_r[i]};
                REG_PRESET: view_s = 32'(preset_r[i]);
                REG_COUNT:  view_s = 32'(count_r[i]);
                REG_STATUS: view_s = {31'd0, pend_r[i]};
                default:    view_s = 32'd0;
            endcase
            rdata = rdata | ({32{sel_s[i]}} & view_s);
        end
    end

    // Interrupts: a channel requests when pending and unmasked. All requests are OR-ed.
    always_comb begin
        irq_ch = pend_r & im_r;
        irq    = |irq_ch;
    end

endmodule

// File: tb/tb_multi_timer_dev.sv
// Self-checking bench for multi_timer_dev (NUM_CH = 2, WIDTH = 32).
// It runs table-driven register vectors, hand-written timing sequences, and a
// randomized phase. The randomized phase is compared against a timeline-based
// reference model of the channel behaviour.
module tb_multi_timer_dev;

    logic        clk;
    logic        reset;
    logic [7:0]  addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [1:0]  irq_ch;
    logic        irq;

    int tests = 0;
    int fails = 0;
    int n;
    logic [31:0] cv, pv;

    multi_timer_dev #(.NUM_CH(2), .WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .be     (be),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq_ch (irq_ch),
        .irq    (irq)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    // act = 0 means the channel is idle. Otherwise pos is the position within one
    // period: pos 0 is the load cycle, pos 1..len are the count cycles, and
    // pos len+1 is the fire cycle.
    typedef struct {
        bit          en, mode, im, pend, act;
        int unsigned pos;
        logic [31:0] preset, count, cap;
    } mch_t;
    mch_t m [2];

    function automatic void model_reset();
        for (int c = 0; c < 2; c++) begin
            m[c].en = 1'b0; m[c].mode = 1'b0; m[c].im = 1'b0; m[c].pend = 1'b0;
            m[c].act = 1'b0; m[c].pos = 0;
            m[c].preset = 32'd0; m[c].count = 32'd0; m[c].cap = 32'd0;
        end
    endfunction

    function automatic void model_step(input logic w, input logic [7:0] a,
                                       input logic [3:0] b, input logic [31:0] d);
        for (int c = 0; c < 2; c++) begin
            bit          fire;
            bit          stop;
            logic [31:0] len;
            logic [31:0] mask;
            fire = 1'b0;
            stop = 1'b0;
            len  = (m[c].cap == 32'd0) ? 32'd1 : m[c].cap;
            mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
            if (!m[c].act) begin
                if (m[c].en) begin
                    m[c].act = 1'b1;
                    m[c].pos = 0;
                end
            end else if (!m[c].en) begin
                m[c].act = 1'b0;
            end else if (m[c].pos == 0) begin
                m[c].cap   = m[c].preset;
                m[c].count = m[c].preset;
                m[c].pos   = 1;
            end else if (m[c].pos <= len) begin
                m[c].count = (m[c].cap > m[c].pos) ? (m[c].cap - m[c].pos) : 32'd0;
                m[c].pos   = m[c].pos + 1;
            end else begin
                fire = 1'b1;
                if (m[c].mode) begin
                    m[c].pos = 0;
                end else begin
                    m[c].act = 1'b0;
                    stop     = 1'b1;
                end
            end
            if (w && (a[7:4] == 4'(c))) begin
                case (a[3:2])
                    2'd0: if (b[0]) begin
                        m[c].en = d[0]; m[c].mode = d[1]; m[c].im = d[2];
                    end
                    2'd1: m[c].preset = (d & mask) | (m[c].preset & ~mask);
                    2'd3: if (b[0] && d[0]) m[c].pend = 1'b0;
                    default: ;
                endcase
            end
            if (stop) m[c].en = 1'b0;
            if (fire) m[c].pend = 1'b1;
        end
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int c;
        c = int'(a[7:4]);
        if (c >= 2) return 32'd0;
        case (a[3:2])
            2'd0:    return {29'd0, m[c].im, m[c].mode, m[c].en};
            2'd1:    return m[c].preset;
            2'd2:    return m[c].count;
            default: return {31'd0, m[c].pend};
        endcase
    endfunction

    function automatic logic [1:0] model_irq_ch();
        return {m[1].pend & m[1].im, m[0].pend & m[0].im};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic tick();
        model_step(we, addr, be, wdata);
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [3:0] b, input logic [31:0] d);
        we = 1'b1; addr = a; be = b; wdata = d;
        tick();
        we = 1'b0; be = 4'd0; wdata = 32'd0;
    endtask

    task automatic chk_rd(input string nm, input logic [7:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(nm, rdata, exp);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [7:0]  waddr;
        logic [3:0]  wbe;
        logic [31:0] wd;
        logic [7:0]  raddr;
        logic [31:0] exp;
    } vec_t;
    vec_t vt [11];

    logic [7:0]  rst_addrs [10];
    logic [31:0] a_cnt [8];
    logic [15:0] b_pend;

    initial begin
        vt[0]  = '{8'h04, 4'b0011, 32'hAABBCCDD, 8'h04, 32'h0000CCDD};
        vt[1]  = '{8'h04, 4'b1000, 32'hFFFFFFFF, 8'h04, 32'hFF00CCDD};
        vt[2]  = '{8'h14, 4'b1111, 32'h12345678, 8'h14, 32'h12345678};
        vt[3]  = '{8'h14, 4'b0100, 32'h00000000, 8'h14, 32'h12005678};
        vt[4]  = '{8'h08, 4'b1111, 32'hFFFFFFFF, 8'h08, 32'h00000000};
        vt[5]  = '{8'h24, 4'b1111, 32'hFFFFFFFF, 8'h24, 32'h00000000};
        vt[6]  = '{8'h00, 4'b1111, 32'hFFFFFFF8, 8'h00, 32'h00000000};
        vt[7]  = '{8'h00, 4'b1110, 32'h00000007, 8'h00, 32'h00000000};
        vt[8]  = '{8'h0C, 4'b1111, 32'hFFFFFFFF, 8'h0C, 32'h00000000};
        vt[9]  = '{8'h13, 4'b0001, 32'h00000006, 8'h10, 32'h00000006};
        vt[10] = '{8'h10, 4'b0001, 32'h00000000, 8'h10, 32'h00000000};
        rst_addrs = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h20, 8'h2C};
        a_cnt     = '{32'd0, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0};
        b_pend    = 16'h8420;

        reset = 1'b1; we = 1'b0; addr = 8'd0; be = 4'd0; wdata = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state.
        for (int i = 0; i < 10; i++) chk_rd("reset_rd", rst_addrs[i], 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        // Table-driven register vectors.
        for (int i = 0; i < 11; i++) begin
            bus_write(vt[i].waddr, vt[i].wbe, vt[i].wd);
            chk_rd("vec_rd", vt[i].raddr, vt[i].exp);
        end

        // Basic one-shot on ch0: PRESET 5, CTRL 0x5. irq rises 8 edges after the write.
        bus_write(8'h04, 4'b1111, 32'd5);
        bus_write(8'h00, 4'b0001, 32'h5);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk_rd("a_count", 8'h08, a_cnt[k-1]);
            check("a_irq", {31'd0, irq}, {31'd0, (k == 8)});
        end
        check("a_irq_ch", {30'd0, irq_ch}, 32'd1);
        chk_rd("a_ctrl", 8'h00, 32'h4);
        bus_write(8'h0C, 4'b1111, 32'd0);
        check("a_w0_noeffect", {31'd0, irq}, 32'd1);
        bus_write(8'h0C, 4'b0001, 32'd1);
        check("a_w1c_irq", {31'd0, irq}, 32'd0);

        // Auto-reload on ch1: PRESET 3, CTRL 0x7. PEND is set every 5 cycles. A W1C on the
        // cycle where FIRE also sets PEND leaves PEND set.
        bus_write(8'h14, 4'b1111, 32'd3);
        bus_write(8'h10, 4'b0001, 32'h7);
        for (int k = 1; k <= 16; k++) begin
            if (k == 7 || k == 12 || k == 16) begin
                we = 1'b1; addr = 8'h1C; be = 4'b0001; wdata = 32'd1;
            end else begin
                we = 1'b0;
            end
            tick();
            we = 1'b0; be = 4'd0; wdata = 32'd0;
            chk_rd("b_pend", 8'h1C, {31'd0, b_pend[k-1]});
            check("b_irq", {31'd0, irq}, {31'd0, b_pend[k-1]});
        end
        bus_write(8'h10, 4'b0001, 32'd0);
        bus_write(8'h1C, 4'b0001, 32'd1);
        check("b_stop_irq", {31'd0, irq}, 32'd0);

        // Masking: ch0 runs with IM = 0, so it is pending but irq stays low. Unmasking raises irq.
        bus_write(8'h04, 4'b1111, 32'd2);
        bus_write(8'h00, 4'b0001, 32'h1);
        n = 0;
        addr = 8'h0C; #1;
        while (rdata !== 32'd1 && n < 20) begin
            tick(); addr = 8'h0C; #1; n++;
        end
        check("c_pend_wait", rdata, 32'd1);
        check("c_masked_irq", {31'd0, irq}, 32'd0);
        check("c_masked_irq_ch", {30'd0, irq_ch}, 32'd0);
        bus_write(8'h00, 4'b0001, 32'h4);
        check("c_unmask_irq", {31'd0, irq}, 32'd1);
        bus_write(8'h0C, 4'b0001, 32'd1);
        check("c_clear_irq", {31'd0, irq}, 32'd0);

        // Disable mid-count: COUNT holds 7, and PEND is never set.
        bus_write(8'h04, 4'b1111, 32'd20);
        bus_write(8'h00, 4'b0001, 32'h5);
        n = 0;
        addr = 8'h08; #1;
        while (rdata !== 32'd8 && n < 40) begin
            tick(); addr = 8'h08; #1; n++;
        end
        check("d_count_wait", rdata, 32'd8);
        bus_write(8'h00, 4'b0001, 32'h4);
        for (int k = 0; k < 6; k++) begin
            chk_rd("d_count_hold", 8'h08, 32'd7);
            chk_rd("d_no_pend", 8'h0C, 32'd0);
            tick();
        end
        chk_rd("d_ctrl", 8'h00, 32'h4);

        // Reset mid-count: ch1 has COUNT 0x10 and PEND set. Everything clears without a clock edge.
        bus_write(8'h14, 4'b1111, 32'h20);
        bus_write(8'h10, 4'b0001, 32'h7);
        n = 0;
        addr = 8'h18; #1; cv = rdata;
        addr = 8'h1C; #1; pv = rdata;
        while (!(cv == 32'h10 && pv == 32'd1) && n < 200) begin
            tick();
            addr = 8'h18; #1; cv = rdata;
            addr = 8'h1C; #1; pv = rdata;
            n++;
        end
        check("e_count", cv, 32'h10);
        check("e_pend", pv, 32'd1);
        check("e_irq_before", {31'd0, irq}, 32'd1);
        reset = 1'b1;
        #1;
        check("e_irq_async", {31'd0, irq}, 32'd0);
        check("e_irq_ch_async", {30'd0, irq_ch}, 32'd0);
        for (int i = 0; i < 8; i++) chk_rd("e_rd_async", rst_addrs[i], 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Randomized phase, compared against the reference model.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) < 3) begin
                we    = 1'b1;
                addr  = {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
                be    = 4'($urandom);
                wdata = ($urandom_range(0, 3) != 0) ? 32'($urandom_range(0, 6)) : 32'($urandom);
            end else begin
                we = 1'b0;
            end
            tick();
            we = 1'b0;
            check("rnd_irq", {31'd0, irq}, {31'd0, |model_irq_ch()});
            check("rnd_irq_ch", {30'd0, irq_ch}, {30'd0, model_irq_ch()});
            addr = {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'b00};
            #1;
            check("rnd_rd", rdata, model_read(addr));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
